// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT_PIPE = 1'b0;
    localparam logic PORT_LOAD = 1'b1;

    localparam int MEM_BYTES_DEF = 24;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signals of the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req0, req1;
    logic          we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          done0, done1;
    logic          err0, err1;
    logic [DW-1:0] rdata0, rdata1;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] write_data;
    logic          memRead, memWrite;
    logic [DW-1:0] read_data;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, read_data,
        output done0, done1, err0, err1, rdata0, rdata1, busy,
               mem_addr, write_data, memRead, memWrite
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, read_data,
        input  done0, done1, err0, err1, rdata0, rdata1, busy,
               mem_addr, write_data, memRead, memWrite
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant with a 1-bit last-grant pointer.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    logic last_q;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last_q == PORT_LOAD) ? 2'b01 : 2'b10;
        end
    end

    // Pointer resets to the loader so the pipeline wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= PORT_LOAD;
        end else if (advance && (req != 2'b00)) begin
            last_q <= gnt[1];
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer for the single-port data memory.
//   state  | meaning
//   IDLE   | strobes low; sample requests, arbitrate, check legality
//   ACCESS | one-cycle memRead/memWrite strobe; reads capture read_data
//   RESP   | done (and err) pulse on the winning port
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int AW        = 32,
    parameter int DW        = 32
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    state_t        state_q;
    logic          port_q;
    logic          we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] write_data_q;
    logic          mem_read_q, mem_write_q;
    logic [1:0]    done_q, err_q;
    logic [DW-1:0] rdata0_q, rdata1_q;

    logic [1:0]    req, gnt;
    logic          sel;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          legal;

    assign req = {bus.req1, bus.req0};

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (state_q == IDLE),
        .gnt     (gnt)
    );

    // Direct unsigned compare so addresses near 2^AW cannot wrap into range.
    always_comb begin
        sel       = gnt[1];
        sel_we    = sel ? bus.we1    : bus.we0;
        sel_addr  = sel ? bus.addr1  : bus.addr0;
        sel_wdata = sel ? bus.wdata1 : bus.wdata0;
        legal     = (sel_addr[1:0] == 2'b00) && (sel_addr <= AW'(MEM_BYTES - 4));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            port_q       <= PORT_PIPE;
            we_q         <= 1'b0;
            mem_addr_q   <= '0;
            write_data_q <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            done_q       <= '0;
            err_q        <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req != 2'b00) begin
                        port_q <= sel;
                        we_q   <= sel_we;
                        if (legal) begin
                            state_q      <= ACCESS;
                            mem_addr_q   <= sel_addr;
                            write_data_q <= sel_wdata;
                            mem_read_q   <= !sel_we;
                            mem_write_q  <= sel_we;
                        end else begin
                            state_q <= RESP;
                            done_q  <= gnt;
                            err_q   <= gnt;
                        end
                    end
                end
                ACCESS: begin
                    state_q      <= RESP;
                    mem_addr_q   <= '0;
                    write_data_q <= '0;
                    mem_read_q   <= 1'b0;
                    mem_write_q  <= 1'b0;
                    done_q       <= (port_q == PORT_LOAD) ? 2'b10 : 2'b01;
                    if (!we_q) begin
                        if (port_q == PORT_LOAD) rdata1_q <= bus.read_data;
                        else                     rdata0_q <= bus.read_data;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    done_q  <= '0;
                    err_q   <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.done0      = done_q[0];
    assign bus.done1      = done_q[1];
    assign bus.err0       = err_q[0];
    assign bus.err1       = err_q[1];
    assign bus.rdata0     = rdata0_q;
    assign bus.rdata1     = rdata1_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.mem_addr   = mem_addr_q;
    assign bus.write_data = write_data_q;
    assign bus.memRead    = mem_read_q;
    assign bus.memWrite   = mem_write_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a transaction-level reference model.
module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MB = 24;
    localparam int NW = MB / 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(.MEM_BYTES(MB), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural data_mem driven by the DUT strobes.
    logic [31:0] env_mem [NW] = '{32'd35, 32'h0, 32'h01010101, 32'h01010101, 32'h0, 32'h0};
    always_comb begin
        bus.read_data = 32'hBAD0BAD0;
        if (bus.mem_addr < 32'(MB)) bus.read_data = env_mem[bus.mem_addr[4:2]];
    end
    always @(posedge clk) begin
        if (bus.memWrite && bus.mem_addr < 32'(MB)) env_mem[bus.mem_addr[4:2]] <= bus.write_data;
    end

    // Reference model: memory image, last grant, per-port read results, pending transactions.
    logic [31:0] m_mem [NW] = '{32'd35, 32'h0, 32'h01010101, 32'h01010101, 32'h0, 32'h0};
    int          m_last;
    logic [31:0] m_rdata [2];
    logic        p_v  [2];
    logic        p_we [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_wd [2];
    int          last_done_cyc [2];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_reqs();
        bus.req0 = p_v[0]; bus.we0 = p_we[0]; bus.addr0 = p_addr[0]; bus.wdata0 = p_wd[0];
        bus.req1 = p_v[1]; bus.we1 = p_we[1]; bus.addr1 = p_addr[1]; bus.wdata1 = p_wd[1];
    endtask

    task automatic issue(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
        p_v[p] = 1'b1; p_we[p] = we; p_addr[p] = a; p_wd[p] = d;
    endtask

    task automatic model_reset();
        m_last = 1;
        for (int i = 0; i < 2; i++) begin
            m_rdata[i] = '0; p_v[i] = 1'b0; p_we[i] = 1'b0; p_addr[i] = '0; p_wd[i] = '0;
            last_done_cyc[i] = -1;
        end
    endtask

    // Entered at a negedge in IDLE; returns at the negedge of the done cycle.
    task automatic run_round(output int w);
        logic legal;
        logic [31:0] done_w, done_o, err_w;
        drive_reqs();
        if (!p_v[0] && !p_v[1]) begin
            w = -1;
            @(negedge clk);
            return;
        end
        if (p_v[0] && p_v[1]) w = (m_last == 1) ? 0 : 1;
        else                  w = p_v[1] ? 1 : 0;
        m_last = w;
        legal = (p_addr[w] % 4 == 0) && (p_addr[w] <= 32'(MB - 4));
        @(negedge clk);
        chk("busy", 32'(bus.busy), 1);
        if (legal) begin
            chk("memRead", 32'(bus.memRead), 32'(!p_we[w]));
            chk("memWrite", 32'(bus.memWrite), 32'(p_we[w]));
            chk("mem_addr", bus.mem_addr, p_addr[w]);
            if (p_we[w]) chk("write_data", bus.write_data, p_wd[w]);
            chk("early_done", 32'({bus.done1, bus.done0}), 0);
            if (p_we[w]) m_mem[p_addr[w] / 4] = p_wd[w];
            else         m_rdata[w] = m_mem[p_addr[w] / 4];
            @(negedge clk);
        end
        done_w = 32'(w == 1 ? bus.done1 : bus.done0);
        done_o = 32'(w == 1 ? bus.done0 : bus.done1);
        err_w  = 32'(w == 1 ? bus.err1 : bus.err0);
        chk(w == 1 ? "done1" : "done0", done_w, 1);
        chk("done_other", done_o, 0);
        chk(w == 1 ? "err1" : "err0", err_w, 32'(!legal));
        chk("rdata0", bus.rdata0, m_rdata[0]);
        chk("rdata1", bus.rdata1, m_rdata[1]);
        chk("strobes_resp", 32'({bus.memRead, bus.memWrite}), 0);
        chk("mem_addr_resp", bus.mem_addr, 0);
        p_v[w] = 1'b0;
    endtask

    // Drives any new requests and moves through RESP->IDLE.
    task automatic settle();
        drive_reqs();
        @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 0);
        chk("idle_strobes", 32'({bus.memRead, bus.memWrite}), 0);
        chk("idle_done", 32'({bus.done1, bus.done0, bus.err1, bus.err0}), 0);
    endtask

    task automatic gen(input int p);
        logic [31:0] a;
        if (!p_v[p] && $urandom_range(0, 3) != 0) begin
            case ($urandom_range(0, 7))
                0:       a = 32'($urandom_range(0, 5) * 4 + $urandom_range(1, 3));
                1:       a = 32'(MB + 4 * $urandom_range(0, 3));
                2:       a = 32'hFFFF_FFFC - 32'(4 * $urandom_range(0, 3));
                default: a = 32'($urandom_range(0, 5) * 4);
            endcase
            issue(p, 1'($urandom_range(0, 1)), a, $urandom);
        end
    endtask

    initial begin
        int w, prev_w;
        model_reset();
        drive_reqs();
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_strobes", 32'({bus.memRead, bus.memWrite}), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_rdata0", bus.rdata0, 0);
        chk("rst_rdata1", bus.rdata1, 0);
        chk("rst_done", 32'({bus.done1, bus.done0}), 0);

        issue(0, 1'b0, 32'd0, 32'd0);
        run_round(w);
        chk("tp_read0", bus.rdata0, 32'd35);
        settle();

        issue(1, 1'b1, 32'd4, 32'hDEADBEEF);
        run_round(w);
        settle();
        issue(0, 1'b0, 32'd4, 32'd0);
        run_round(w);
        chk("tp_wr_rd", bus.rdata0, 32'hDEADBEEF);
        settle();

        // Both ports saturated: grants alternate, each port served every 6 cycles.
        issue(0, 1'b0, 32'd8, 32'd0);
        issue(1, 1'b0, 32'd12, 32'd0);
        prev_w = -1;
        for (int k = 0; k < 6; k++) begin
            run_round(w);
            if (prev_w >= 0) chk("alternate", 32'(w != prev_w), 1);
            if (w >= 0 && last_done_cyc[w] >= 0) chk("period", 32'(cyc - last_done_cyc[w]), 6);
            if (w >= 0) begin
                last_done_cyc[w] = cyc;
                chk("sat_rdata", w == 1 ? bus.rdata1 : bus.rdata0, 32'h01010101);
                if (k < 5) issue(w, 1'b0, w == 1 ? 32'd12 : 32'd8, 32'd0);
            end
            prev_w = w;
            settle();
        end
        run_round(w);
        settle();

        issue(0, 1'b0, 32'd2, 32'd0);          run_round(w); chk("err_misal", 32'(bus.err0), 1); settle();
        issue(0, 1'b0, 32'd24, 32'd0);         run_round(w); chk("err_range", 32'(bus.err0), 1); settle();
        issue(0, 1'b0, 32'hFFFF_FFFC, 32'd0);  run_round(w); chk("err_wrap", 32'(bus.err0), 1); settle();

        issue(1, 1'b1, 32'd16, 32'h11); run_round(w); settle();
        issue(1, 1'b1, 32'd16, 32'h22); run_round(w); settle();
        issue(1, 1'b0, 32'd16, 32'd0);  run_round(w); chk("b2b_wr", bus.rdata1, 32'h22); settle();

        for (int r = 0; r < 200; r++) begin
            gen(0);
            gen(1);
            run_round(w);
            settle();
        end
        for (int r = 0; r < 2; r++) begin
            run_round(w);
            settle();
        end

        // Load rdata0 with a known non-zero value, then abort a read mid-ACCESS.
        issue(0, 1'b0, 32'd8, 32'd0); run_round(w); settle();
        issue(0, 1'b0, 32'd8, 32'd0);
        drive_reqs();
        @(posedge clk);
        #1;
        chk("mid_access_rd", 32'(bus.memRead), 1);
        #1 reset = 1'b0;
        #1;
        chk("rst_async_strobe", 32'({bus.memRead, bus.memWrite}), 0);
        chk("rst_async_done", 32'(bus.done0), 0);
        chk("rst_async_rdata0", bus.rdata0, 0);
        chk("rst_async_addr", bus.mem_addr, 0);
        model_reset();
        drive_reqs();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(0, 1'b0, 32'd8, 32'd0);
        issue(1, 1'b0, 32'd12, 32'd0);
        run_round(w);
        chk("first_tie", 32'(w), 0);
        settle();
        run_round(w);
        chk("second_tie", 32'(w), 1);
        settle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the single-port data memory (`data_mem`). It shares the memory between the pipeline MEM stage (port 0) and the program/debug loader (port 1), using round-robin arbitration. Each access is sequenced as a one-cycle strobe, and misaligned or out-of-range accesses are rejected with an error response. Read data is registered back to the winning requester with a done pulse.

## Interface
Parameters:
- `MEM_BYTES`, 24, byte size of the data memory; highest legal word address is MEM_BYTES-4.
- `AW`, 32, address width.
- `DW`, 32, data width.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  reset, asynchronous, active-low
- `req0`, `req1`  in  1  access request, port 0 (pipeline) / port 1 (loader)
- `we0`, `we1`  in  1  1 = write, 0 = read
- `addr0`, `addr1`  in  AW  byte address
- `wdata0`, `wdata1`  in  DW  write data
- `done0`, `done1`  out  1  one-cycle completion pulse
- `err0`, `err1`  out  1  valid with done; 1 = rejected, no memory access
- `rdata0`, `rdata1`  out  DW  read result; valid with done, held until that port's next read done
- `busy`  out  1  high in any state other than IDLE
- `mem_addr`  out  AW  to memory
- `write_data`  out  DW  to memory
- `memRead`, `memWrite`  out  1  memory strobes
- `read_data`  in  DW  from memory (combinational)

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, arbitrate, latch the winner's port id, we, addr and wdata, and check legality.
  - Legal means addr[1:0]==0 and addr <= MEM_BYTES-4.
  - Legal access goes to ACCESS; illegal access goes to RESP with the error flag set.
- ACCESS:
  - Lasts exactly one cycle.
  - Drive mem_addr and write_data from the latched values.
  - Assert memRead (read) or memWrite (write), never both.
  - A read captures read_data into the winner's rdata register at the end of the cycle.
  - Next state is RESP.
- RESP:
  - Pulse done (and err if illegal) on the winning port only.
  - Next state is IDLE.
  - Requests arriving in RESP are not sampled until IDLE.
- Strobes and mem_addr are 0 in IDLE and RESP.
  - Every access therefore produces a strobe edge, which the event-sensitive memory needs.
  - This includes back-to-back writes to the same address.
- Arbitration: round-robin on a 1-bit last-grant pointer.
  - Both requesting: grant the port not granted last.
  - Single requester: always granted.
  - The pointer updates on every grant, including error grants.
- Requester rules:
  - Hold req and its fields stable from assertion until done.
  - Deassert req in the cycle after done unless issuing a new transaction.
  - A req high in IDLE is always a new transaction.
- Error responses: rdata is unchanged and memory is untouched.
- Write responses: rdata is unchanged.
- Address arithmetic is unsigned AW-bit. An addr near 2^AW must not wrap into legal range, so compare addr directly against MEM_BYTES-4.

## Timing
- Request sampled at edge N (IDLE), ACCESS during cycle N..N+1, done high during N+1..N+2, IDLE again at N+2.
- Legal latency: 2 cycles from sampling edge to done. Error latency: 1 cycle (IDLE→RESP).
- Sustained throughput: one access per 3 cycles. With both ports saturated, each port is served every 6 cycles.
- Reset asserted (any state, including mid-ACCESS):
  - state=IDLE; last-grant=1, so port 0 wins the first tie.
  - All outputs 0, including rdata0/rdata1.
  - Strobes drop immediately (asynchronous).
  - An aborted write may or may not have reached memory; no done is issued.
- First sampling edge after reset release: normal IDLE behaviour.

## Structure
- Shared package `dmem_pkg`: state enum {IDLE, ACCESS, RESP}, port-id constants PORT_PIPE=0 and PORT_LOAD=1, and the MEM_BYTES default.
- Sub-module `rr_arb2`:
  - 2-requester round-robin grant logic plus the last-grant register.
  - Inputs: `clk`, `reset`, `req[1:0]`, `advance`. Outputs: one-hot `gnt[1:0]`.
- Top level holds the FSM, the latch registers, the legality check and the per-port response registers.

## Test plan
- Reset, then port0 read addr=0 → memRead high for 1 cycle with mem_addr=0; done0 2 cycles later with rdata0=35, err0=0.
- Port1 write addr=4 data=0xDEADBEEF, then port0 read addr=4 → memWrite pulse then memRead pulse; rdata0=0xDEADBEEF.
- req0 and req1 both held continuously for reads of addr 8 and 12 → grants alternate 0,1,0,1. rdata1=0x01010101 and rdata0=0x01010101 every 6 cycles each.
- Port0 read addr=2 (misaligned), then addr=24 (out of range), then addr=0xFFFFFFFC → each gives done0 with err0=1 one cycle after sampling. No strobe asserted, rdata0 unchanged.
- Two consecutive port1 writes to addr 16 (0x11, then 0x22), then a read → two separate memWrite pulses separated by idle cycles; read returns 0x22.
- Assert reset during ACCESS of a port0 read → strobes, done0 and rdata0 go 0 immediately. After release, a simultaneous req0/req1 grants port 0 first.
